// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU encodings: access sizes, memory controller states, IO region tag.
package cpu_defs;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Upper two bits of the RAM window that mark an address as IO.
    localparam logic [1:0] IO_REGION = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } mem_state_t;

    function automatic logic [2:0] beat_count(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial memory port arbiter for instruction fetch and load/store traffic.
module mem_ctrl
    import cpu_defs::*;
#(
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clr_in,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);

    mem_state_t  state, state_nxt;
    logic        is_ls, is_wr;
    logic [31:0] addr, wdata, rd_buf, rd_merged, beat_addr;
    logic [2:0]  n, ic, cc;
    logic        pending, gap;
    logic        beat_io, issue_rd, issue_wr, capture, last_capture, grant_ls, grant_if;

    always_comb begin
        beat_addr    = addr + {29'd0, ic};
        beat_io      = (beat_addr[RAM_ADDR_WIDTH -: 2] == IO_REGION);
        issue_rd     = (state == READ) && rdy_in && (ic < n);
        issue_wr     = (state == WRITE) && rdy_in && !gap && !(beat_io && io_buffer_full);
        capture      = (state == READ) && rdy_in && pending;
        last_capture = capture && (cc == n - 3'd1);
        grant_ls     = (state == IDLE) && rdy_in && !clr_in && ls_req;
        grant_if     = (state == IDLE) && rdy_in && !clr_in && !ls_req && if_req;
        rd_merged    = rd_buf;
        rd_merged[{cc[1:0], 3'b000} +: 8] = mem_din;
        mem_a    = (issue_rd || issue_wr) ? beat_addr : 32'd0;
        mem_wr   = issue_wr;
        mem_dout = issue_wr ? wdata[{ic[1:0], 3'b000} +: 8] : 8'd0;
        // A flush kills a pending read result but never a store already under way.
        if_done  = (state == DONE) && !is_ls && rdy_in && !clr_in;
        ls_done  = (state == DONE) && is_ls && rdy_in && (is_wr || !clr_in);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_ls)      state_nxt = ls_wr ? WRITE : READ;
                else if (grant_if) state_nxt = READ;
            end
            READ: begin
                if (rdy_in) begin
                    if (clr_in)            state_nxt = IDLE;
                    else if (last_capture) state_nxt = DONE;
                end
            end
            WRITE: begin
                if (issue_wr && (ic == n - 3'd1)) state_nxt = DONE;
            end
            DONE: begin
                if (rdy_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            is_ls    <= 1'b0;
            is_wr    <= 1'b0;
            addr     <= 32'd0;
            wdata    <= 32'd0;
            n        <= 3'd0;
            ic       <= 3'd0;
            cc       <= 3'd0;
            pending  <= 1'b0;
            gap      <= 1'b0;
            rd_buf   <= 32'd0;
            if_data  <= 32'd0;
            ls_rdata <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_ls || grant_if) begin
                        is_ls   <= grant_ls;
                        is_wr   <= grant_ls && ls_wr;
                        addr    <= grant_ls ? ls_addr : if_addr;
                        wdata   <= ls_wdata;
                        n       <= grant_ls ? beat_count(ls_size) : 3'd4;
                        ic      <= 3'd0;
                        cc      <= 3'd0;
                        pending <= 1'b0;
                        gap     <= 1'b0;
                        rd_buf  <= 32'd0;
                    end
                end
                READ: begin
                    if (!rdy_in) begin
                        // The byte in flight is lost while paused; re-issue from the first missing one.
                        pending <= 1'b0;
                        ic      <= cc;
                    end else begin
                        pending <= issue_rd;
                        if (issue_rd) ic <= ic + 3'd1;
                        if (capture) begin
                            rd_buf <= rd_merged;
                            cc     <= cc + 3'd1;
                            if (last_capture) begin
                                if (is_ls) ls_rdata <= rd_merged;
                                else       if_data  <= rd_merged;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (rdy_in) begin
                        if (gap) begin
                            gap <= 1'b0;
                        end else if (issue_wr) begin
                            ic  <= ic + 3'd1;
                            // UART full flag lags a cycle, so each IO byte is followed by a quiet cycle.
                            gap <= beat_io;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed and randomized checks of mem_ctrl against a byte-array reference.
module tb_mem_ctrl;

    localparam int RAM_BYTES = 262144;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clr_in, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req, if_done, ls_req, ls_wr, ls_done;
    logic [31:0] if_addr, if_data, ls_addr, ls_wdata, ls_rdata;
    logic [1:0]  ls_size;

    mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] seed_byte(input int i);
        logic [31:0] v;
        case (i)
            4:       return 8'h13;
            5:       return 8'h05;
            6:       return 8'h00;
            7:       return 8'h00;
            'h200:   return 8'hAB;
            default: begin
                v = i * 29 + (i >> 5);
                return v[7:0];
            end
        endcase
    endfunction

    // Environment RAM with one-cycle read latency.
    logic [7:0] ram [0:RAM_BYTES-1];
    bit         ram_init = 1'b0;
    always @(posedge clk_in) begin
        if (!ram_init) begin
            for (int i = 0; i < RAM_BYTES; i++) ram[i] = seed_byte(i);
            ram_init <= 1'b1;
            mem_din  <= 8'd0;
        end else begin
            if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
            mem_din <= ram[mem_a[17:0]];
        end
    end

    logic [7:0]  ref_mem [0:RAM_BYTES-1];
    int          checks = 0;
    int          passed = 0;
    int          done_off, wr_count, ls_off, if_off;
    logic [31:0] got_data, if_got;
    logic [31:0] log_a [0:63];
    logic        log_wr [0:63];
    logic [7:0]  log_d [0:63];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] v, ak;
        v = 32'd0;
        for (int k = 0; k < n; k++) begin
            ak = a + k;
            v[8*k +: 8] = ref_mem[ak[17:0]];
        end
        return v;
    endfunction

    task automatic ref_write(input logic [31:0] a, input int n, input logic [31:0] wd);
        logic [31:0] ak;
        for (int k = 0; k < n; k++) begin
            ak = a + k;
            ref_mem[ak[17:0]] = wd[8*k +: 8];
        end
    endtask

    function automatic bit is_io(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction

    // Starts at posedge+1 with the DUT idle; offset 0 is the grant cycle.
    task automatic run(input bit fetch, input bit wr, input logic [1:0] size,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int stall_at, input int stall_len, input int full_n,
                       input int clr_at, input int budget);
        for (int i = 0; i < 64; i++) begin
            log_a[i] = 32'd0; log_wr[i] = 1'b0; log_d[i] = 8'd0;
        end
        if (fetch) begin
            if_req = 1'b1; if_addr = a;
        end else begin
            ls_req = 1'b1; ls_wr = wr; ls_size = size; ls_addr = a; ls_wdata = wd;
        end
        done_off = -1;
        wr_count = 0;
        for (int off = 0; off <= budget; off++) begin
            rdy_in         = !(off >= stall_at && off < stall_at + stall_len);
            io_buffer_full = off < full_n;
            clr_in         = (off == clr_at);
            if (clr_at >= 0 && off > clr_at && (fetch || !wr)) begin
                if_req = 1'b0; ls_req = 1'b0;
            end
            @(negedge clk_in);
            log_a[off] = mem_a; log_wr[off] = mem_wr; log_d[off] = mem_dout;
            if (mem_wr) wr_count++;
            if (if_done || ls_done) begin
                done_off = off;
                got_data = if_done ? if_data : ls_rdata;
            end
            @(posedge clk_in); #1;
            if (done_off >= 0) break;
        end
        if_req = 1'b0; ls_req = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; clr_in = 1'b0;
    endtask

    initial begin
        logic [31:0] a, wd, t;
        logic [1:0]  sz;
        int          kind, n, exp_done;
        bit          ok;

        rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0; ls_req = 1'b0; ls_wr = 1'b0;
        ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
        for (int i = 0; i < RAM_BYTES; i++) ref_mem[i] = seed_byte(i);

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("rst_if_done", {31'd0, if_done}, 32'd0);
        check("rst_ls_done", {31'd0, ls_done}, 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_ls_rdata", ls_rdata, 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // Fetch at 0x4.
        run(1, 0, 2'd2, 32'h4, 32'd0, -100, 0, 0, -1, 20);
        for (int k = 0; k < 4; k++) check("fetch_addr", log_a[1+k], 32'h4 + k);
        check("fetch_done_cycle", done_off, 6);
        check("fetch_data", got_data, 32'h00000513);

        // Halfword store then readback.
        run(0, 1, 2'd1, 32'h100, 32'h00001234, -100, 0, 0, -1, 20);
        check("sh_wr1", {31'd0, log_wr[1]}, 32'd1);
        check("sh_a1", log_a[1], 32'h100);
        check("sh_d1", {24'd0, log_d[1]}, 32'h34);
        check("sh_wr2", {31'd0, log_wr[2]}, 32'd1);
        check("sh_a2", log_a[2], 32'h101);
        check("sh_d2", {24'd0, log_d[2]}, 32'h12);
        check("sh_done_cycle", done_off, 3);
        ref_write(32'h100, 2, 32'h00001234);
        run(0, 0, 2'd1, 32'h100, 32'd0, -100, 0, 0, -1, 20);
        check("lh_readback", got_data, 32'h00001234);
        check("lh_done_cycle", done_off, 4);

        // Simultaneous requests: load wins, fetch follows.
        for (int i = 0; i < 64; i++) log_a[i] = 32'd0;
        if_req = 1'b1; if_addr = 32'h10; ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h200;
        ls_off = -1; if_off = -1;
        for (int off = 0; off < 30; off++) begin
            @(negedge clk_in);
            log_a[off] = mem_a;
            if (ls_done) begin ls_off = off; got_data = ls_rdata; end
            if (if_done) begin if_off = off; if_got = if_data; end
            @(posedge clk_in); #1;
            if (ls_off >= 0) ls_req = 1'b0;
            if (if_off >= 0) break;
        end
        if_req = 1'b0; ls_req = 1'b0;
        check("arb_ls_done_cycle", ls_off, 3);
        check("arb_ls_data", got_data, 32'h000000AB);
        check("arb_fetch_addr", log_a[5], 32'h10);
        check("arb_if_done_cycle", if_off, 10);
        check("arb_if_data", if_got, ref_read(32'h10, 4));

        // IO store held off by a full UART buffer.
        run(0, 1, 2'd0, 32'h30000, 32'h41, -100, 0, 5, -1, 20);
        check("io_wr_count", wr_count, 1);
        check("io_wr_cycle", {31'd0, log_wr[5]}, 32'd1);
        check("io_addr", log_a[5], 32'h30000);
        check("io_data", {24'd0, log_d[5]}, 32'h41);
        check("io_done_cycle", done_off, 6);
        ref_write(32'h30000, 1, 32'h41);

        // Word load paused for three cycles after byte 1 is captured.
        run(0, 0, 2'd2, 32'h40, 32'd0, 4, 3, 0, -1, 30);
        check("stall_reissue_addr", log_a[7], 32'h42);
        check("stall_data", got_data, ref_read(32'h40, 4));
        check("stall_done_cycle", done_off, 10);

        // Flushed fetch, then a clean fetch of the same word.
        run(1, 0, 2'd2, 32'h20, 32'd0, -100, 0, 0, 2, 12);
        check("clr_fetch_no_done", done_off, -1);
        check("clr_fetch_idle", log_a[3], 32'd0);
        run(1, 0, 2'd2, 32'h20, 32'd0, -100, 0, 0, -1, 20);
        check("post_clr_done_cycle", done_off, 6);
        check("post_clr_data", got_data, ref_read(32'h20, 4));

        // Flush during a word store must not stop it.
        run(0, 1, 2'd2, 32'h80, 32'hDEADBEEF, -100, 0, 0, 2, 20);
        check("clr_store_done_cycle", done_off, 5);
        check("clr_store_bytes", wr_count, 4);
        ref_write(32'h80, 4, 32'hDEADBEEF);
        run(0, 0, 2'd2, 32'h80, 32'd0, -100, 0, 0, -1, 20);
        check("clr_store_readback", got_data, 32'hDEADBEEF);

        // Randomized mix of fetches, loads and stores, including IO and window-edge addresses.
        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 2);
            sz   = 2'($urandom_range(0, 2));
            n    = (kind == 0) ? 4 : (sz == 2'd0 ? 1 : (sz == 2'd1 ? 2 : 4));
            wd   = $urandom;
            if (kind == 0) a = 32'($urandom_range(0, 63) * 4);
            else a = (($urandom_range(0, 3) == 0) ? 32'h3FFF0 : 32'h0) + 32'($urandom_range(0, 31));
            run(kind == 0, kind == 2, sz, a, wd, -100, 0, 0, -1, 40);
            if (kind != 2) begin
                check("rand_read_done_cycle", done_off, n + 2);
                check("rand_read_data", got_data, ref_read(a, n));
            end else begin
                ok = 1'b1;
                exp_done = 1;
                for (int k = 0; k < n; k++) begin
                    t = a + k;
                    if (!(log_wr[exp_done] && log_a[exp_done] == t && log_d[exp_done] == wd[8*k +: 8])) ok = 1'b0;
                    exp_done = exp_done + (is_io(t) && k < n - 1 ? 2 : 1);
                end
                check("rand_store_beats", {31'd0, ok}, 32'd1);
                check("rand_store_count", wr_count, n);
                check("rand_store_done_cycle", done_off, exp_done);
                ref_write(a, n, wd);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
